// File: rtl/term_pkg.sv
// Shared types and constants for the terminal output arbiter.
package term_pkg;

    localparam int unsigned CHAR_W = 8;
    localparam int unsigned TI_W   = 7;

    localparam logic [CHAR_W-1:0] CR = 8'h0D;

    typedef enum logic {
        SRC_CPU,
        SRC_AUX
    } src_t;

    typedef enum logic {
        G_IDLE,
        G_ISSUE
    } gstate_t;

    // Round-robin pick: a lone non-empty source wins, a tie goes to the one not granted last.
    function automatic src_t pick_src(input logic cpu_ne, input logic aux_ne, input src_t last);
        src_t sel;
        if (cpu_ne && !aux_ne) begin
            sel = SRC_CPU;
        end else if (!cpu_ne && aux_ne) begin
            sel = SRC_AUX;
        end else begin
            sel = (last == SRC_AUX) ? SRC_CPU : SRC_AUX;
        end
        return sel;
    endfunction

endpackage

// File: rtl/term_out_arbiter_char_fifo.sv
// Small character FIFO with wrap-bit pointers; full/empty/level derive from registered pointers.
module char_fifo
    import term_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [CHAR_W-1:0]       wdata,
    input  logic                    pop,
    output logic [CHAR_W-1:0]       rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [AW:0]        wptr_q, wptr_d;
    logic [AW:0]        rptr_q, rptr_d;
    logic [CHAR_W-1:0]  mem_q [DEPTH];
    logic [CHAR_W-1:0]  mem_d [DEPTH];
    logic               push_ok;
    logic               pop_ok;

    assign level   = wptr_q - rptr_q;
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    // Next-state for pointers and storage.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (push_ok) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d                = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointer and storage registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mem_q  <= '{default: '0};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/term_out_arbiter.sv
// Round-robin scheduler of CPU and aux characters onto the single terminal write port.
module term_out_arbiter
    import term_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_wr,
    input  logic [CHAR_W-1:0]       cpu_data,
    output logic                    cpu_busy,
    input  logic                    aux_valid,
    input  logic [CHAR_W-1:0]       aux_data,
    output logic                    aux_ready,
    input  logic                    tready,
    output logic                    te,
    output logic [TI_W-1:0]         ti,
    output logic [$clog2(DEPTH):0]  cpu_level,
    output logic [$clog2(DEPTH):0]  aux_level,
    output logic                    ovf
);

    logic               cpu_full, cpu_empty;
    logic               aux_full, aux_empty;
    logic [CHAR_W-1:0]  cpu_head, aux_head;
    logic               pop_cpu, pop_aux;
    logic               aux_push;
    src_t               sel;

    gstate_t            state_q, state_d;
    src_t               last_q, last_d;
    logic               te_q, te_d;
    logic [TI_W-1:0]    ti_q, ti_d;
    logic               ovf_q, ovf_d;

    // The terminal only takes 7-bit characters; the top bit is intentionally discarded.
    logic               unused_head_msb;
    assign unused_head_msb = cpu_head[CHAR_W-1] ^ aux_head[CHAR_W-1];

    assign aux_push  = aux_valid && !aux_full;
    assign cpu_busy  = cpu_full;
    assign aux_ready = !aux_full;
    assign te        = te_q;
    assign ti        = ti_q;
    assign ovf       = ovf_q;

    char_fifo #(
        .DEPTH (DEPTH)
    ) u_cpu_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cpu_wr),
        .wdata (cpu_data),
        .pop   (pop_cpu),
        .rdata (cpu_head),
        .full  (cpu_full),
        .empty (cpu_empty),
        .level (cpu_level)
    );

    char_fifo #(
        .DEPTH (DEPTH)
    ) u_aux_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (aux_push),
        .wdata (aux_data),
        .pop   (pop_aux),
        .rdata (aux_head),
        .full  (aux_full),
        .empty (aux_empty),
        .level (aux_level)
    );

    // Grant decision, FIFO pops and next values of the registered terminal outputs.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        te_d    = 1'b0;
        ti_d    = ti_q;
        pop_cpu = 1'b0;
        pop_aux = 1'b0;
        ovf_d   = ovf_q || (cpu_wr && cpu_full);
        sel     = pick_src(!cpu_empty, !aux_empty, last_q);
        unique case (state_q)
            G_IDLE: begin
                // An empty window leaves last-grant untouched.
                if (tready && (!cpu_empty || !aux_empty)) begin
                    if (sel == SRC_CPU) begin
                        pop_cpu = 1'b1;
                        ti_d    = cpu_head[TI_W-1:0];
                    end else begin
                        pop_aux = 1'b1;
                        ti_d    = aux_head[TI_W-1:0];
                    end
                    te_d    = 1'b1;
                    last_d  = sel;
                    state_d = G_ISSUE;
                end
            end
            G_ISSUE: begin
                // tready is ignored here so each window yields at most one write.
                state_d = G_IDLE;
            end
        endcase
    end

    // Grant FSM and output registers; reset drops te asynchronously and lets the CPU win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= G_IDLE;
            last_q  <= SRC_AUX;
            te_q    <= 1'b0;
            ti_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            te_q    <= te_d;
            ti_q    <= ti_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_term_out_arbiter.sv
// Directed self-checking bench for term_out_arbiter.
module tb_term_out_arbiter;
    import term_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        cpu_wr;
    logic [7:0]  cpu_data;
    logic        cpu_busy;
    logic        aux_valid;
    logic [7:0]  aux_data;
    logic        aux_ready;
    logic        tready;
    logic        te;
    logic [6:0]  ti;
    logic [2:0]  cpu_level;
    logic [2:0]  aux_level;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    term_out_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_wr    (cpu_wr),
        .cpu_data  (cpu_data),
        .cpu_busy  (cpu_busy),
        .aux_valid (aux_valid),
        .aux_data  (aux_data),
        .aux_ready (aux_ready),
        .tready    (tready),
        .te        (te),
        .ti        (ti),
        .cpu_level (cpu_level),
        .aux_level (aux_level),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic cpu_push(input logic [7:0] d);
        cpu_wr   = 1'b1;
        cpu_data = d;
        tick();
        cpu_wr   = 1'b0;
    endtask

    task automatic aux_push(input logic [7:0] d);
        aux_valid = 1'b1;
        aux_data  = d;
        tick();
        aux_valid = 1'b0;
    endtask

    // tready stays high through the ISSUE cycle, which must not produce a second write.
    task automatic expect_char(input string tag, input logic [7:0] exp);
        tready = 1'b1;
        tick();
        check({tag, " te"}, 32'(te), 32'd1);
        check({tag, " ti"}, 32'(ti), 32'(exp[6:0]));
        tick();
        check({tag, " te drop"}, 32'(te), 32'd0);
        tready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_wr    = 1'b0;
        cpu_data  = '0;
        aux_valid = 1'b0;
        aux_data  = '0;
        tready    = 1'b0;

        // Reset state
        do_reset();
        check("rst te", 32'(te), 32'd0);
        check("rst ti", 32'(ti), 32'd0);
        check("rst cpu_busy", 32'(cpu_busy), 32'd0);
        check("rst aux_ready", 32'(aux_ready), 32'd1);
        check("rst ovf", 32'(ovf), 32'd0);
        check("rst cpu_level", 32'(cpu_level), 32'd0);
        check("rst aux_level", 32'(aux_level), 32'd0);

        // Single character, bit 7 stripped
        cpu_push(8'hC1);
        check("single level1", 32'(cpu_level), 32'd1);
        tick();
        tick();
        check("single no te early", 32'(te), 32'd0);
        expect_char("single", 8'hC1);
        check("single level0", 32'(cpu_level), 32'd0);

        // Simultaneous push and pop keeps the level
        cpu_push(8'h21);
        cpu_wr   = 1'b1;
        cpu_data = 8'h22;
        tready   = 1'b1;
        tick();
        cpu_wr   = 1'b0;
        tready   = 1'b0;
        check("pushpop te", 32'(te), 32'd1);
        check("pushpop ti", 32'(ti), 32'h21);
        check("pushpop level", 32'(cpu_level), 32'd1);
        tick();
        expect_char("pushpop next", 8'h22);

        // Round-robin from a fresh reset: CPU wins the first tie
        do_reset();
        cpu_push(8'h41);
        cpu_push(8'h42);
        aux_push(8'h61);
        aux_push(8'h62);
        check("rr cpu_level", 32'(cpu_level), 32'd2);
        check("rr aux_level", 32'(aux_level), 32'd2);
        expect_char("rr0", 8'h41);
        expect_char("rr1", 8'h61);
        expect_char("rr2", 8'h42);
        expect_char("rr3", 8'h62);
        check("rr drained cpu", 32'(cpu_level), 32'd0);
        check("rr drained aux", 32'(aux_level), 32'd0);

        // Overflow
        do_reset();
        cpu_push(8'hB1);
        cpu_push(8'h32);
        cpu_push(8'h33);
        check("ovf busy at 3", 32'(cpu_busy), 32'd0);
        cpu_push(8'h34);
        check("ovf busy at 4", 32'(cpu_busy), 32'd1);
        check("ovf not yet", 32'(ovf), 32'd0);
        cpu_push(8'h35);
        check("ovf set", 32'(ovf), 32'd1);
        check("ovf level", 32'(cpu_level), 32'd4);
        expect_char("drain0", 8'h31);
        check("ovf busy clears", 32'(cpu_busy), 32'd0);
        expect_char("drain1", 8'h32);
        expect_char("drain2", 8'h33);
        expect_char("drain3", 8'h34);
        tready = 1'b1;
        tick();
        check("drain extra te", 32'(te), 32'd0);
        tready = 1'b0;
        check("ovf sticky", 32'(ovf), 32'd1);

        // Aux full drops aux_ready
        for (int i = 0; i < 4; i++) aux_push(8'h70 + 8'(i));
        check("aux full ready", 32'(aux_ready), 32'd0);
        check("aux full level", 32'(aux_level), 32'd4);

        // Empty windows; then a tie still goes to the CPU, CR passes through
        do_reset();
        check("empty ovf cleared", 32'(ovf), 32'd0);
        tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("empty te", 32'(te), 32'd0);
        end
        tready = 1'b0;
        cpu_wr    = 1'b1;
        cpu_data  = CR;
        aux_valid = 1'b1;
        aux_data  = 8'h5A;
        tick();
        cpu_wr    = 1'b0;
        aux_valid = 1'b0;
        expect_char("empty cr", CR);
        expect_char("empty aux", 8'h5A);

        // Reset on the te cycle
        do_reset();
        cpu_push(8'h41);
        cpu_push(8'h42);
        cpu_push(8'h43);
        tready = 1'b1;
        tick();
        tready = 1'b0;
        check("mid te before", 32'(te), 32'd1);
        reset = 1'b1;
        #1;
        check("mid te async", 32'(te), 32'd0);
        check("mid cpu_level", 32'(cpu_level), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            tready = 1'b1;
            tick();
            check("mid post te", 32'(te), 32'd0);
            tready = 1'b0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
